threshold_cutter_block_reader: RTL and testbench

Reads completed sample blocks out of the threshold-cutter block BRAM and streams them to the downstream consumer (DMA/PS bridge) as a valid/ready word stream. It sits on the BRAM read port, opposite the threshold-cutter window writer. It tracks how many finished blocks are waiting, reads them in order one word per clock under backpressure, and marks block boundaries.

---
 rtl/threshold_cutter_block_reader.sv | 166 ++++++++++++++++
 tb/tb_threshold_cutter_block_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_cutter_block_reader.sv
// Streams completed threshold-cutter blocks out of BRAM as valid/ready words, in block order.
// First word 3 clocks after blk_done; m_ready low halts reads at once, at most 2 words buffered.
module threshold_cutter_block_reader #(
    parameter int BLOCK_NUM_INDEX   = 6,
    parameter int BLOCK_DEPTH_INDEX = 9,
    parameter int BLOCK_DEPTH       = 400,
    parameter int DATA_WIDTH        = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       blk_done,
    output logic                                       bram_ren,
    output logic [BLOCK_NUM_INDEX+BLOCK_DEPTH_INDEX-1:0] bram_raddr,
    input  logic [DATA_WIDTH-1:0]                      bram_rdata,
    output logic [DATA_WIDTH-1:0]                      m_data,
    output logic                                       m_valid,
    input  logic                                       m_ready,
    output logic                                       m_last,
    output logic [BLOCK_NUM_INDEX-1:0]                 m_block_no,
    output logic [BLOCK_NUM_INDEX:0]                   pending,
    output logic                                       overflow
);

    localparam logic [BLOCK_NUM_INDEX:0]     PEND_MAX = {1'b1, {BLOCK_NUM_INDEX{1'b0}}};
    localparam logic [BLOCK_NUM_INDEX:0]     PEND_ONE = {{BLOCK_NUM_INDEX{1'b0}}, 1'b1};
    localparam logic [BLOCK_NUM_INDEX-1:0]   BLK_ONE  = {{(BLOCK_NUM_INDEX-1){1'b0}}, 1'b1};
    localparam logic [BLOCK_DEPTH_INDEX-1:0] PTR_ONE  = {{(BLOCK_DEPTH_INDEX-1){1'b0}}, 1'b1};
    localparam logic [BLOCK_DEPTH_INDEX-1:0] PTR_LAST = BLOCK_DEPTH_INDEX'(BLOCK_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]      data;
        logic                       last;
        logic [BLOCK_NUM_INDEX-1:0] blk;
    } entry_t;

    state_t                       state_q, state_d;
    logic [BLOCK_NUM_INDEX-1:0]   rd_block_q, rd_block_d;
    logic [BLOCK_DEPTH_INDEX-1:0] rd_ptr_q, rd_ptr_d;
    logic [BLOCK_NUM_INDEX:0]     pending_q, pending_d;
    logic                         overflow_q, overflow_d;
    logic                         rd_vld_q, rd_vld_d;
    logic                         rd_last_q, rd_last_d;
    logic [BLOCK_NUM_INDEX-1:0]   rd_blk_q, rd_blk_d;
    entry_t [1:0]                 fifo_q, fifo_d;
    logic                         fifo_wptr_q, fifo_wptr_d;
    logic                         fifo_rptr_q, fifo_rptr_d;
    logic [1:0]                   fifo_cnt_q, fifo_cnt_d;

    entry_t     head;
    logic       pop, pop_last, issue;
    logic [2:0] occ_after_pop;

    always_comb begin
        head          = fifo_q[fifo_rptr_q];
        pop           = (fifo_cnt_q != 2'd0) && m_ready;
        pop_last      = pop && head.last;
        // Reads take two edges to land in the buffer; bram_ren is decided in
        // the same cycle so one outstanding read plus one buffered word
        // keeps a full-rate stream inside two entries.
        occ_after_pop = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
        issue         = (state_q == READ) && (occ_after_pop < 3'd2);
    end

    always_comb begin
        state_d     = state_q;
        rd_block_d  = rd_block_q;
        rd_ptr_d    = rd_ptr_q;
        pending_d   = pending_q;
        overflow_d  = overflow_q;
        rd_vld_d    = issue;
        rd_last_d   = (rd_ptr_q == PTR_LAST);
        rd_blk_d    = rd_block_q;
        fifo_d      = fifo_q;
        fifo_wptr_d = fifo_wptr_q;
        fifo_rptr_d = fifo_rptr_q;
        fifo_cnt_d  = fifo_cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};

        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    state_d  = READ;
                    rd_ptr_d = '0;
                end
            end
            READ: begin
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    if (rd_ptr_q == PTR_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_last) begin
                    rd_block_d = rd_block_q + BLK_ONE;
                    rd_ptr_d   = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_vld_q) begin
            fifo_d[fifo_wptr_q].data = bram_rdata;
            fifo_d[fifo_wptr_q].last = rd_last_q;
            fifo_d[fifo_wptr_q].blk  = rd_blk_q;
            fifo_wptr_d              = ~fifo_wptr_q;
        end
        if (pop) begin
            fifo_rptr_d = ~fifo_rptr_q;
        end

        // A full counter cannot absorb another block: the writer has lapped us.
        if (blk_done && !pop_last) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_ONE;
            end
        end else if (!blk_done && pop_last) begin
            pending_d = pending_q - PEND_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_block_q  <= '0;
            rd_ptr_q    <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_blk_q    <= '0;
            fifo_q      <= '0;
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            rd_block_q  <= rd_block_d;
            rd_ptr_q    <= rd_ptr_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            rd_blk_q    <= rd_blk_d;
            fifo_q      <= fifo_d;
            fifo_wptr_q <= fifo_wptr_d;
            fifo_rptr_q <= fifo_rptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    assign bram_ren   = issue;
    assign bram_raddr = {rd_block_q, rd_ptr_q};
    assign m_valid    = (fifo_cnt_q != 2'd0);
    assign m_data     = head.data;
    assign m_last     = head.last;
    assign m_block_no = head.blk;
    assign pending    = pending_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_threshold_cutter_block_reader.sv
// Directed bench for threshold_cutter_block_reader with a synchronous BRAM model.
module tb_threshold_cutter_block_reader;

    localparam int BN    = 6;
    localparam int BD    = 9;
    localparam int DEPTH = 400;
    localparam int DW    = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             blk_done = 1'b0;
    logic             m_ready = 1'b0;
    logic             bram_ren, m_valid, m_last, overflow;
    logic [BN+BD-1:0] bram_raddr;
    logic [DW-1:0]    bram_rdata, m_data;
    logic [BN-1:0]    m_block_no;
    logic [BN:0]      pending;

    logic [DW-1:0] mem [0:(1<<(BN+BD))-1];

    int vectors     = 0;
    int miscompares = 0;
    int exp_blk     = 0;
    int exp_word    = 0;
    int iss_blk     = 0;
    int iss_word    = 0;
    int cyc;

    threshold_cutter_block_reader #(
        .BLOCK_NUM_INDEX(BN), .BLOCK_DEPTH_INDEX(BD), .BLOCK_DEPTH(DEPTH), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .blk_done(blk_done),
        .bram_ren(bram_ren), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .m_block_no(m_block_no), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_ren) bram_rdata <= mem[bram_raddr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] exp_data(input int b, input int w);
        return DW'(b * 65536 + w);
    endfunction

    // Commits the inputs of the current cycle, checks any read issued in it
    // against the strictly sequential address order, then moves to the next negedge.
    task automatic tick();
        logic [BN+BD-1:0] ea;
        #2;
        if (rst) begin
            iss_blk  = 0;
            iss_word = 0;
        end else if (bram_ren) begin
            ea = (BN+BD)'(iss_blk * 512 + iss_word);
            vectors++;
            if (bram_raddr !== ea) begin
                miscompares++;
                $display("FAIL raddr_seq: got %h, expected %h", bram_raddr, ea);
            end
            iss_word++;
            if (iss_word == DEPTH) begin iss_word = 0; iss_blk = (iss_blk + 1) % 64; end
        end
        @(negedge clk);
    endtask

    // Consumes n beats, checking each visible word against the expected order.
    // Returns at the negedge whose following edge pops the n-th beat.
    task automatic stream_beats(input int n, input bit rnd, input int budget, output int cycles);
        int got;
        logic [DW-1:0] ed;
        logic el;
        got = 0;
        cycles = 0;
        while (got < n) begin
            if (m_valid) begin
                ed = exp_data(exp_blk, exp_word);
                el = (exp_word == DEPTH - 1);
                vectors++;
                if (m_data !== ed || m_last !== el || m_block_no !== BN'(exp_blk)) begin
                    miscompares++;
                    $display("FAIL beat: got blk %0d data %h last %b, expected blk %0d data %h last %b",
                             m_block_no, m_data, m_last, exp_blk, ed, el);
                end
            end
            m_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            if (m_valid && m_ready) begin
                got++;
                exp_word++;
                if (exp_word == DEPTH) begin exp_word = 0; exp_blk = (exp_blk + 1) % 64; end
            end
            if (got < n) begin
                if (cycles >= budget) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL stream_timeout: got %0d beats, expected %0d", got, n);
                    break;
                end
                cycles++;
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (bram_ren !== 1'b0) begin miscompares++; $display("FAIL reset_ren: got %b, expected 0", bram_ren); end
        vectors++; if (bram_raddr !== '0) begin miscompares++; $display("FAIL reset_raddr: got %h, expected 0", bram_raddr); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, expected 0", m_valid); end
        vectors++; if (m_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h, expected 0", m_data); end
        vectors++; if (m_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b, expected 0", m_last); end
        vectors++; if (m_block_no !== '0) begin miscompares++; $display("FAIL reset_blkno: got %0d, expected 0", m_block_no); end
        vectors++; if (pending !== '0) begin miscompares++; $display("FAIL reset_pending: got %0d, expected 0", pending); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        rst = 1'b0;
        exp_blk = 0;
        exp_word = 0;
        tick();
    endtask

    task automatic test_single_block();
        m_ready = 1'b1;
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        vectors++; if (pending !== 7'd1) begin miscompares++; $display("FAIL single_pending_up: got %0d, expected 1", pending); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_e0: got %b, expected 0", m_valid); end
        tick();
        vectors++; if (bram_ren !== 1'b1 || bram_raddr !== '0) begin miscompares++; $display("FAIL single_first_read: got ren %b addr %h, expected 1 0", bram_ren, bram_raddr); end
        tick();
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_e2: got %b, expected 0", m_valid); end
        tick();
        vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid_e3: got %b, expected 1", m_valid); end
        stream_beats(DEPTH, 1'b0, 600, cyc);
        vectors++; if (cyc !== DEPTH - 1) begin miscompares++; $display("FAIL single_back_to_back: got %0d cycles, expected %0d", cyc, DEPTH - 1); end
        tick();
        vectors++; if (pending !== 7'd0 || m_valid !== 1'b0) begin miscompares++; $display("FAIL single_done: got pending %0d valid %b, expected 0 0", pending, m_valid); end
    endtask

    task automatic test_simultaneous();
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        stream_beats(10, 1'b0, 100, cyc);
        vectors++; if (pending !== 7'd1) begin miscompares++; $display("FAIL simul_pre: got %0d, expected 1", pending); end
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        vectors++; if (pending !== 7'd2) begin miscompares++; $display("FAIL simul_nonlast: got %0d, expected 2", pending); end
        stream_beats(DEPTH - 10, 1'b0, 600, cyc);
        vectors++; if (m_last !== 1'b1) begin miscompares++; $display("FAIL simul_at_last: got last %b, expected 1", m_last); end
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        vectors++; if (pending !== 7'd2) begin miscompares++; $display("FAIL simul_last: got %0d, expected 2", pending); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL gap_ep0: got valid %b, expected 0", m_valid); end
        tick();
        vectors++; if (m_valid !== 1'b0 || bram_ren !== 1'b1 || bram_raddr !== 15'd1024) begin miscompares++; $display("FAIL gap_ep1: got valid %b ren %b addr %h, expected 0 1 400", m_valid, bram_ren, bram_raddr); end
        tick();
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL gap_ep2: got valid %b, expected 0", m_valid); end
        tick();
        vectors++; if (m_valid !== 1'b1 || m_block_no !== 6'd2 || m_data !== 32'h0002_0000) begin miscompares++; $display("FAIL gap_ep3: got valid %b blk %0d data %h, expected 1 2 00020000", m_valid, m_block_no, m_data); end
        stream_beats(2 * DEPTH, 1'b0, 1000, cyc);
        tick();
        vectors++; if (pending !== 7'd0) begin miscompares++; $display("FAIL simul_drain: got %0d, expected 0", pending); end
    endtask

    task automatic test_random_backpressure();
        m_ready = 1'b0;
        blk_done = 1'b1;
        tick();
        tick();
        tick();
        blk_done = 1'b0;
        vectors++; if (pending !== 7'd3) begin miscompares++; $display("FAIL rand_queued: got %0d, expected 3", pending); end
        stream_beats(3 * DEPTH, 1'b1, 8000, cyc);
        m_ready = 1'b1;
        tick();
        vectors++; if (pending !== 7'd0) begin miscompares++; $display("FAIL rand_pending: got %0d, expected 0", pending); end
        for (int i = 0; i < 4; i++) tick();
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rand_extra_beat: got valid %b, expected 0", m_valid); end
    endtask

    task automatic test_overflow();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_blk = 0;
        exp_word = 0;
        m_ready = 1'b0;
        blk_done = 1'b1;
        for (int i = 0; i < 64; i++) tick();
        vectors++; if (pending !== 7'd64 || overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_full: got pending %0d ovf %b, expected 64 0", pending, overflow); end
        tick();
        blk_done = 1'b0;
        vectors++; if (pending !== 7'd64 || overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got pending %0d ovf %b, expected 64 1", pending, overflow); end
        vectors++; if (m_valid !== 1'b1 || m_data !== '0 || bram_ren !== 1'b0) begin miscompares++; $display("FAIL ovf_stall: got valid %b data %h ren %b, expected 1 0 0", m_valid, m_data, bram_ren); end
        for (int i = 0; i < 10; i++) tick();
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (overflow !== 1'b0 || pending !== '0) begin miscompares++; $display("FAIL ovf_rst: got ovf %b pending %0d, expected 0 0", overflow, pending); end
        tick();
    endtask

    task automatic test_wrap();
        exp_blk = 0;
        exp_word = 0;
        m_ready = 1'b0;
        blk_done = 1'b1;
        for (int i = 0; i < 64; i++) tick();
        blk_done = 1'b0;
        vectors++; if (pending !== 7'd64) begin miscompares++; $display("FAIL wrap_queued: got %0d, expected 64", pending); end
        stream_beats(DEPTH, 1'b0, 600, cyc);
        tick();
        vectors++; if (pending !== 7'd63) begin miscompares++; $display("FAIL wrap_first_done: got %0d, expected 63", pending); end
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        stream_beats(63 * DEPTH, 1'b0, 63 * DEPTH + 400, cyc);
        vectors++; if (m_block_no !== 6'd63 || m_last !== 1'b1) begin miscompares++; $display("FAIL wrap_blk63: got blk %0d last %b, expected 63 1", m_block_no, m_last); end
        tick();
        tick();
        vectors++; if (bram_ren !== 1'b1 || bram_raddr !== '0) begin miscompares++; $display("FAIL wrap_addr: got ren %b addr %h, expected 1 0", bram_ren, bram_raddr); end
        stream_beats(DEPTH, 1'b0, 600, cyc);
        tick();
        vectors++; if (pending !== 7'd0) begin miscompares++; $display("FAIL wrap_done: got %0d, expected 0", pending); end
    endtask

    task automatic test_reset_mid_block();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_blk = 0;
        exp_word = 0;
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        stream_beats(150, 1'b0, 300, cyc);
        tick();
        rst = 1'b1;
        tick();
        vectors++; if (bram_ren !== 1'b0 || bram_raddr !== '0) begin miscompares++; $display("FAIL midrst_read: got ren %b addr %h, expected 0 0", bram_ren, bram_raddr); end
        vectors++; if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || m_block_no !== '0) begin miscompares++; $display("FAIL midrst_stream: got valid %b data %h last %b blk %0d, expected all 0", m_valid, m_data, m_last, m_block_no); end
        vectors++; if (pending !== '0) begin miscompares++; $display("FAIL midrst_pending: got %0d, expected 0", pending); end
        rst = 1'b0;
        exp_blk = 0;
        exp_word = 0;
        tick();
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        stream_beats(DEPTH, 1'b0, 600, cyc);
        tick();
        vectors++; if (pending !== 7'd0) begin miscompares++; $display("FAIL midrst_restream: got %0d, expected 0", pending); end
    endtask

    initial begin
        for (int b = 0; b < 64; b++)
            for (int w = 0; w < 512; w++)
                mem[b * 512 + w] = exp_data(b, w);
        test_reset();
        test_single_block();
        test_simultaneous();
        test_random_backpressure();
        test_overflow();
        test_wrap();
        test_reset_mid_block();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
